alu_bist_ctrl: RTL and testbench
================================

// Module: alu_bist_ctrl
// PURPOSE
//  Built-in self-test driver/checker for the combinational ALU: generates operand/op vectors,
//  drives the ALU inputs, samples result + 4 flags, compares against an internal golden model.
//  Sits beside the ALU in the execute stage; muxed onto ALU inputs in test mode.
// PARAMETERS
//  NUM_VECTORS  256            random vectors per run (1..65535)
//  LFSR_SEED    32'hACE1_0001  operand1 LFSR seed; operand2 seed = ~LFSR_SEED (must be nonzero)
//  OP_MASK      8'hFF          bit i=1 -> compare enabled for alu_op i; 0 -> vector driven, not checked
// PORTS
//  clk            in   1   clock
//  rst_n          in   1   synchronous active-low reset
//  start          in   1   1-cycle run request; ignored while busy
//  busy           out  1   run in progress
//  done           out  1   run complete; held until next accepted start
//  pass           out  1   done && err_count==0
//  err_count      out  16  mismatching vectors, saturates at 16'hFFFF
//  fail_idx       out  16  index of first failing vector (0 if none)
//  fail_op        out  4   alu_op of first failing vector (0 if none)
//  alu_operand1   out  32  to ALU operand1
//  alu_operand2   out  32  to ALU operand2
//  alu_op         out  4   to ALU alu_op
//  alu_result     in   32  from ALU result
//  alu_zero       in   1   from ALU zero_flag
//  alu_negative   in   1   from ALU negative_flag
//  alu_overflow   in   1   from ALU overflow_flag
//  alu_carry      in   1   from ALU carry_flag
// BEHAVIOUR
//  - Reset (rst_n==0 at posedge): every output 0, FSM->IDLE, LFSRs reload seeds. Reset mid-run aborts;
//    no partial status retained.
//  - FSM: IDLE -start-> DRIVE -> CHECK -> (DRIVE if more vectors else DONE); DONE -start-> DRIVE.
//  - 2 cycles/vector, non-pipelined. DRIVE: register vector idx onto alu_* outputs. CHECK: compare ALU
//    outputs vs golden computed from the registered alu_* values; update err/fail regs at end of CHECK.
//  - busy=1 from cycle after accepted start for exactly 2*total_vectors cycles; done=1 the next cycle.
//  - start accepted in IDLE or DONE only: clears err_count/fail_*, done, pass; LFSRs reload seeds.
//  - Vector idx (0-based): alu_op = {1'b0, idx[2:0]}; operands = two Galois LFSRs, poly 32'h8020_0003,
//    stepped once per DRIVE (vector 0 uses seeds).
//  - Golden model, s = operand2[4:0]:
//    0 ADD a+b; 1 SUB a-b; 2 AND; 3 OR; 4 XOR; 5 SLL a<<s; 6 SRL a>>s; 7 SRA $signed(a)>>>s.
//    zero = (result==0); negative = result[31] for all ops.
//    ADD: carry = bit32 of {0,a}+{0,b}; overflow = a[31]==b[31] && r[31]!=a[31].
//    SUB: carry = bit32 of {0,a}-{0,b} (borrow); overflow = a[31]!=b[31] && r[31]!=a[31].
//    ops 2-7: carry=0, overflow=0.
//  - Mismatch = any of the 5 fields differs AND OP_MASK[op]==1. First mismatch latches fail_idx/fail_op;
//    later ones only increment err_count. At 16'hFFFF err_count holds.
//  - pass registered with done; pass=0 whenever done=0.
// CONFIGURATION
//  ALU_BIST_DIRECTED_EN defined: 8 directed vectors precede the random ones, idx 0..7:
//    ADD 1,2; SUB 5,2; AND F,A; OR F,A; XOR F,A; SLL F,2; SRL F,2; SRA 8000_0000,2.
//    Random vectors follow at idx 8.., op = idx[2:0]; LFSRs step only during random vectors;
//    total_vectors = 8+NUM_VECTORS.
//  Not defined: total_vectors = NUM_VECTORS; no directed logic synthesised.
// TESTING (bench: behavioural ALU, optional fault injection; NUM_VECTORS=16)
//  1 Reset, no start -> all outputs 0 incl. alu_operand1/2 and alu_op.
//  2 Fault-free ALU, start pulse -> busy 32 cycles, then done=1 pass=1 err_count=0 fail_idx=0.
//  3 SUB result bit0 inverted -> err_count=2 (idx 1,9), fail_idx=1, fail_op=1, pass=0.
//  4 Same fault, OP_MASK=8'hFD -> pass=1, err_count=0.
//  5 rst_n=0 at cycle 10 of run -> next cycle busy=0 done=0 err_count=0; restart completes in 32 cycles.
//  6 ALU_BIST_DIRECTED_EN, start -> first DRIVE: operand1=1 operand2=2 op=0; busy 48 cycles, pass=1.
//    Start pulses during busy ignored in all runs.

Source files
------------

// File: rtl/alu_bist_ctrl.sv
// Built-in self-test driver/checker for the combinational ALU: drives LFSR-generated vectors,
// checks result and flags against a golden model. Optional directed prologue: ALU_BIST_DIRECTED_EN.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start after reset
// S_DRIVE | register vector idx onto alu_* outputs
// S_CHECK | compare ALU response against golden model, update error status
// S_DONE  | run complete, status held until next accepted start
module alu_bist_ctrl #(
    parameter int unsigned NUM_VECTORS = 256,
    parameter logic [31:0] LFSR_SEED   = 32'hACE1_0001,
    parameter logic [7:0]  OP_MASK     = 8'hFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [15:0] fail_idx,
    output logic [3:0]  fail_op,
    output logic [31:0] alu_operand1,
    output logic [31:0] alu_operand2,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    input  logic        alu_negative,
    input  logic        alu_overflow,
    input  logic        alu_carry
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [31:0] LFSR_POLY  = 32'h8020_0003;
    localparam logic [31:0] LFSR_SEED2 = ~LFSR_SEED;

`ifdef ALU_BIST_DIRECTED_EN
    localparam int unsigned TOTAL_VECTORS = NUM_VECTORS + 8;
`else
    localparam int unsigned TOTAL_VECTORS = NUM_VECTORS;
`endif
    localparam logic [16:0] LAST_IDX = 17'(TOTAL_VECTORS - 1);

    logic [1:0]  state;
    logic [16:0] idx;
    logic [31:0] lfsr1;
    logic [31:0] lfsr2;
    logic [2:0]  op_r;

    logic [32:0] g_sum;
    logic [32:0] g_dif;
    logic [31:0] g_result;
    logic        g_zero;
    logic        g_negative;
    logic        g_overflow;
    logic        g_carry;
    logic        mismatch;
    logic        start_ok;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

`ifdef ALU_BIST_DIRECTED_EN
    function automatic logic [63:0] directed_vec(input logic [2:0] k);
        logic [63:0] v;
        v = 64'h0;
        case (k)
            3'd0: v = {32'h0000_0001, 32'h0000_0002};
            3'd1: v = {32'h0000_0005, 32'h0000_0002};
            3'd2: v = {32'h0000_000F, 32'h0000_000A};
            3'd3: v = {32'h0000_000F, 32'h0000_000A};
            3'd4: v = {32'h0000_000F, 32'h0000_000A};
            3'd5: v = {32'h0000_000F, 32'h0000_0002};
            3'd6: v = {32'h0000_000F, 32'h0000_0002};
            default: v = {32'h8000_0000, 32'h0000_0002};
        endcase
        return v;
    endfunction
`endif

    assign alu_op   = {1'b0, op_r};
    assign busy     = (state == S_DRIVE) || (state == S_CHECK);
    assign done     = (state == S_DONE);
    assign start_ok = start && ((state == S_IDLE) || (state == S_DONE));

    // Golden response computed from the registered vector currently on the ALU inputs.
    always_comb begin
        g_sum      = {1'b0, alu_operand1} + {1'b0, alu_operand2};
        g_dif      = {1'b0, alu_operand1} - {1'b0, alu_operand2};
        g_result   = 32'h0;
        g_overflow = 1'b0;
        g_carry    = 1'b0;
        case (op_r)
            3'd0: begin
                g_result   = g_sum[31:0];
                g_carry    = g_sum[32];
                g_overflow = (alu_operand1[31] == alu_operand2[31]) &&
                             (g_sum[31] != alu_operand1[31]);
            end
            3'd1: begin
                g_result   = g_dif[31:0];
                g_carry    = g_dif[32];
                g_overflow = (alu_operand1[31] != alu_operand2[31]) &&
                             (g_dif[31] != alu_operand1[31]);
            end
            3'd2: g_result = alu_operand1 & alu_operand2;
            3'd3: g_result = alu_operand1 | alu_operand2;
            3'd4: g_result = alu_operand1 ^ alu_operand2;
            3'd5: g_result = alu_operand1 << alu_operand2[4:0];
            3'd6: g_result = alu_operand1 >> alu_operand2[4:0];
            default: g_result = $signed(alu_operand1) >>> alu_operand2[4:0];
        endcase
        g_zero     = (g_result == 32'h0);
        g_negative = g_result[31];
        mismatch   = OP_MASK[op_r] &&
                     ((alu_result   != g_result)   ||
                      (alu_zero     != g_zero)     ||
                      (alu_negative != g_negative) ||
                      (alu_overflow != g_overflow) ||
                      (alu_carry    != g_carry));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            idx          <= 17'd0;
            lfsr1        <= LFSR_SEED;
            lfsr2        <= LFSR_SEED2;
            op_r         <= 3'd0;
            alu_operand1 <= 32'h0;
            alu_operand2 <= 32'h0;
            err_count    <= 16'h0;
            fail_idx     <= 16'h0;
            fail_op      <= 4'h0;
            pass         <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_ok) begin
                        state     <= S_DRIVE;
                        idx       <= 17'd0;
                        lfsr1     <= LFSR_SEED;
                        lfsr2     <= LFSR_SEED2;
                        err_count <= 16'h0;
                        fail_idx  <= 16'h0;
                        fail_op   <= 4'h0;
                        pass      <= 1'b0;
                    end
                end
                S_DRIVE: begin
                    op_r  <= idx[2:0];
                    state <= S_CHECK;
`ifdef ALU_BIST_DIRECTED_EN
                    if (idx < 17'd8) begin
                        alu_operand1 <= directed_vec(idx[2:0])[63:32];
                        alu_operand2 <= directed_vec(idx[2:0])[31:0];
                    end else begin
                        alu_operand1 <= lfsr1;
                        alu_operand2 <= lfsr2;
                        lfsr1        <= lfsr_step(lfsr1);
                        lfsr2        <= lfsr_step(lfsr2);
                    end
`else
                    alu_operand1 <= lfsr1;
                    alu_operand2 <= lfsr2;
                    lfsr1        <= lfsr_step(lfsr1);
                    lfsr2        <= lfsr_step(lfsr2);
`endif
                end
                S_CHECK: begin
                    // err_count never returns to zero mid-run, so zero marks "no failure yet".
                    if (mismatch) begin
                        if (err_count == 16'h0) begin
                            fail_idx <= idx[15:0];
                            fail_op  <= {1'b0, op_r};
                        end
                        if (err_count != 16'hFFFF) begin
                            err_count <= err_count + 16'h1;
                        end
                    end
                    if (idx == LAST_IDX) begin
                        state <= S_DONE;
                        pass  <= (err_count == 16'h0) && !mismatch;
                    end else begin
                        idx   <= idx + 17'd1;
                        state <= S_DRIVE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_bist_ctrl.sv
// Bench for alu_bist_ctrl: two instances (OP_MASK FF / FD) beside a behavioural ALU with a
// single-bit result fault; expectations come from a vector-list reference model.
module tb_alu_bist_ctrl;

    localparam int NV = 16;
`ifdef ALU_BIST_DIRECTED_EN
    localparam int TOTAL = NV + 8;
`else
    localparam int TOTAL = NV;
`endif
    localparam logic [31:0] SEED = 32'hACE1_0001;
    localparam logic [31:0] POLY = 32'h8020_0003;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start;
    logic f_en;
    logic [2:0] f_op;
    logic [4:0] f_bit;

    logic        busy_a, done_a, pass_a, z_a, n_a, ov_a, cy_a;
    logic [15:0] err_a, fidx_a;
    logic [3:0]  fop_a, op_a;
    logic [31:0] a1_a, a2_a, res_a;
    logic [35:0] g_a;

    logic        busy_b, done_b, pass_b, z_b, n_b, ov_b, cy_b;
    logic [15:0] err_b, fidx_b;
    logic [3:0]  fop_b, op_b;
    logic [31:0] a1_b, a2_b, res_b;
    logic [35:0] g_b;

    logic [31:0] vec_a [TOTAL];
    logic [31:0] vec_b [TOTAL];
    logic [2:0]  vec_op[TOTAL];

    int n_tests = 0;
    int n_fail  = 0;

    alu_bist_ctrl #(.NUM_VECTORS(NV), .LFSR_SEED(SEED), .OP_MASK(8'hFF)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_a), .fail_idx(fidx_a), .fail_op(fop_a),
        .alu_operand1(a1_a), .alu_operand2(a2_a), .alu_op(op_a),
        .alu_result(res_a), .alu_zero(z_a), .alu_negative(n_a),
        .alu_overflow(ov_a), .alu_carry(cy_a));

    alu_bist_ctrl #(.NUM_VECTORS(NV), .LFSR_SEED(SEED), .OP_MASK(8'hFD)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .fail_idx(fidx_b), .fail_op(fop_b),
        .alu_operand1(a1_b), .alu_operand2(a2_b), .alu_op(op_b),
        .alu_result(res_b), .alu_zero(z_b), .alu_negative(n_b),
        .alu_overflow(ov_b), .alu_carry(cy_b));

    function automatic logic [35:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
        logic [32:0] w;
        logic [31:0] r;
        logic v, c;
        w = 33'h0; r = 32'h0; v = 1'b0; c = 1'b0;
        case (op)
            3'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; c = w[32];
                        v = (a[31] == b[31]) && (r[31] != a[31]); end
            3'd1: begin w = {1'b0, a} - {1'b0, b}; r = w[31:0]; c = w[32];
                        v = (a[31] != b[31]) && (r[31] != a[31]); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = a << b[4:0];
            3'd6: r = a >> b[4:0];
            default: r = $signed(a) >>> b[4:0];
        endcase
        return {r, (r == 32'h0), r[31], v, c};
    endfunction

    // Behavioural ALUs; the fault flips one result bit for one opcode, flags stay correct.
    always_comb begin
        g_a   = alu_ref(a1_a, a2_a, op_a[2:0]);
        res_a = g_a[35:4] ^ ((f_en && op_a[2:0] == f_op) ? (32'h1 << f_bit) : 32'h0);
        {z_a, n_a, ov_a, cy_a} = g_a[3:0];
        g_b   = alu_ref(a1_b, a2_b, op_b[2:0]);
        res_b = g_b[35:4] ^ ((f_en && op_b[2:0] == f_op) ? (32'h1 << f_bit) : 32'h0);
        {z_b, n_b, ov_b, cy_b} = g_b[3:0];
    end

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
    endfunction

    task automatic build_vectors();
        logic [31:0] s1, s2;
        s1 = SEED;
        s2 = ~SEED;
        for (int k = 0; k < TOTAL; k++) begin
            vec_op[k] = 3'(k % 8);
`ifdef ALU_BIST_DIRECTED_EN
            if (k < 8) begin
                case (k)
                    0: begin vec_a[k] = 32'h1; vec_b[k] = 32'h2; end
                    1: begin vec_a[k] = 32'h5; vec_b[k] = 32'h2; end
                    2, 3, 4: begin vec_a[k] = 32'hF; vec_b[k] = 32'hA; end
                    5, 6: begin vec_a[k] = 32'hF; vec_b[k] = 32'h2; end
                    default: begin vec_a[k] = 32'h8000_0000; vec_b[k] = 32'h2; end
                endcase
                continue;
            end
`endif
            vec_a[k] = s1;
            vec_b[k] = s2;
            s1 = lfsr_next(s1);
            s2 = lfsr_next(s2);
        end
    endtask

    // Reference outcome over the first nvec vectors: a vector fails iff its op is the faulted
    // one and that op is checked by the mask.
    task automatic predict(input logic [7:0] mask, input int nvec,
                           output int err, output int fidx, output int fop);
        err = 0; fidx = 0; fop = 0;
        for (int k = 0; k < nvec; k++) begin
            if (f_en && vec_op[k] == f_op && mask[f_op]) begin
                if (err == 0) begin
                    fidx = k;
                    fop  = int'(vec_op[k]);
                end
                err++;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_and_check(input string tag, input bit chk_vec);
        int busy_n, e, fi, fo, k;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check({tag, "_busy_start"}, 32'(busy_a), 32'd1);
        check({tag, "_done_clr"},   32'(done_a), 32'd0);
        check({tag, "_pass_clr"},   32'(pass_a), 32'd0);
        check({tag, "_err_clr"},    32'(err_a),  32'd0);
        busy_n = 0;
        for (int i = 1; i <= 2 * TOTAL + 8; i++) begin
            if (!busy_a) break;
            busy_n++;
            if (chk_vec && (i % 2 == 0)) begin
                k = i / 2 - 1;
                check({tag, "_op1"}, a1_a, vec_a[k]);
                check({tag, "_op2"}, a2_a, vec_b[k]);
                check({tag, "_op"},  32'(op_a), 32'({1'b0, vec_op[k]}));
            end
            start = ($urandom_range(0, 5) == 0);
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'(2 * TOTAL));
        predict(8'hFF, TOTAL, e, fi, fo);
        check({tag, "_a_done"}, 32'(done_a), 32'd1);
        check({tag, "_a_pass"}, 32'(pass_a), (e == 0) ? 32'd1 : 32'd0);
        check({tag, "_a_err"},  32'(err_a),  32'(e));
        check({tag, "_a_fidx"}, 32'(fidx_a), 32'(fi));
        check({tag, "_a_fop"},  32'(fop_a),  32'(fo));
        predict(8'hFD, TOTAL, e, fi, fo);
        check({tag, "_b_done"}, 32'(done_b), 32'd1);
        check({tag, "_b_pass"}, 32'(pass_b), (e == 0) ? 32'd1 : 32'd0);
        check({tag, "_b_err"},  32'(err_b),  32'(e));
        check({tag, "_b_fidx"}, 32'(fidx_b), 32'(fi));
    endtask

    initial begin
        int e, fi, fo;
        rst_n = 1'b0; start = 1'b0; f_en = 1'b0; f_op = 3'd0; f_bit = 5'd0;
        build_vectors();
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_pass", 32'(pass_a), 32'd0);
        check("rst_err",  32'(err_a),  32'd0);
        check("rst_fidx", 32'(fidx_a), 32'd0);
        check("rst_fop",  32'(fop_a),  32'd0);
        check("rst_op1",  a1_a, 32'd0);
        check("rst_op2",  a2_a, 32'd0);
        check("rst_op",   32'(op_a), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", 32'(busy_a), 32'd0);

        run_and_check("clean", 1'b1);

        f_en = 1'b1; f_op = 3'd1; f_bit = 5'd0;
        run_and_check("sub_bit0", 1'b0);

        // Abort mid-run after some failures have been recorded.
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (9) @(negedge clk);
        predict(8'hFF, 4, e, fi, fo);
        check("abort_err_pre", 32'(err_a), 32'(e));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", 32'(busy_a), 32'd0);
        check("abort_done", 32'(done_a), 32'd0);
        check("abort_err",  32'(err_a),  32'd0);
        check("abort_fidx", 32'(fidx_a), 32'd0);
        check("abort_op",   32'(op_a),   32'd0);
        run_and_check("restart", 1'b1);

        for (int it = 0; it < 6; it++) begin
            f_en  = ($urandom_range(0, 3) != 0);
            f_op  = 3'($urandom_range(0, 7));
            f_bit = 5'($urandom_range(0, 31));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_and_check("rand", 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
